// File: rtl/wfq_ftime_pipe_if.sv
// Request/result bundle between the classifier, the WFQ finish-time engine and the sorter.
// master = requester side, slave = engine side.
interface wfq_ftime_pipe_if #(
   parameter int DW = 16,
   parameter int FW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] in_flow;
   logic [DW-1:0] in_len;
   logic [DW-1:0] in_weight;
   logic [DW-1:0] in_vtime;
   logic          in_idle;
   logic          out_valid;
   logic [FW-1:0] out_flow;
   logic [DW-1:0] out_ftime;
   logic          out_ovf;

   modport master (
      output in_valid, in_flow, in_len, in_weight, in_vtime, in_idle,
      input  in_ready, out_valid, out_flow, out_ftime, out_ovf
   );

   modport slave (
      input  in_valid, in_flow, in_len, in_weight, in_vtime, in_idle,
      output in_ready, out_valid, out_flow, out_ftime, out_ovf
   );
endinterface

// File: rtl/wfq_ftime_pipe.sv
// WFQ finish-time engine: ftime = S + floor(len/weight), S = idle ? V : max(V, F_prev(flow)).
// Latency DW+4, one request per cycle; no output backpressure, in_ready low only during table init.
module wfq_ftime_pipe #(
   parameter int DW  = 16,
   parameter int FW  = 4,
   parameter int SAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   wfq_ftime_pipe_if.slave bus
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   typedef struct packed {
      logic          vld;
      logic [FW-1:0] flow;
      logic [DW-1:0] vtime;
      logic          idle;
      logic          wz;
      logic [DW-1:0] w;
      logic [DW-1:0] dvd;
      logic [DW-1:0] rem;
      logic [DW-1:0] quo;
   } div_t;

   typedef struct packed {
      logic          vld;
      logic [FW-1:0] flow;
      logic [DW-1:0] ftime;
      logic          ovf;
   } res_t;

   state_t        state_q, state_d;
   logic [FW-1:0] sweep_q, sweep_d;
   logic          ready;
   logic          tbl_clr;
   logic          accept;

   div_t          div_q [DW+1];
   div_t          div_d [DW+1];
   div_t          upd;
   res_t          res_q [4];
   res_t          res_d;
   logic [DW-1:0] tbl_q [2**FW];

   logic [DW-1:0] fprev;
   logic [DW-1:0] start;
   logic [DW:0]   sum;

   // ---------------- init FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_INIT: begin
            sweep_d = sweep_q + FW'(1);
            if (sweep_q == '1) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ready   = (state_q == ST_RUN);
      tbl_clr = (state_q == ST_INIT);
   end

   assign accept       = bus.in_valid && ready;
   assign bus.in_ready = ready;

   // ---------------- restoring divider, one quotient bit per stage ----------------
   always_comb begin
      logic [DW:0] trial;
      trial          = '0;
      div_d[0]       = '0;
      div_d[0].vld   = accept;
      div_d[0].flow  = bus.in_flow;
      div_d[0].vtime = bus.in_vtime;
      div_d[0].idle  = bus.in_idle;
      div_d[0].wz    = (bus.in_weight == '0);
      div_d[0].w     = bus.in_weight;
      div_d[0].dvd   = bus.in_len;
      for (int i = 1; i <= DW; i++) begin
         div_d[i]     = div_q[i-1];
         trial        = {div_q[i-1].rem, div_q[i-1].dvd[DW-1]};
         div_d[i].dvd = {div_q[i-1].dvd[DW-2:0], 1'b0};
         // weight 0 always passes the trial compare, giving an all-ones quotient
         if (trial >= {1'b0, div_q[i-1].w}) begin
            div_d[i].rem = trial[DW-1:0] - div_q[i-1].w;
            div_d[i].quo = {div_q[i-1].quo[DW-2:0], 1'b1};
         end else begin
            div_d[i].rem = trial[DW-1:0];
            div_d[i].quo = {div_q[i-1].quo[DW-2:0], 1'b0};
         end
      end
   end

   // ---------------- table update ----------------
   // The table is written on the same edge the result is registered, so the
   // next request (even on the following cycle) reads the fresh value.
   assign upd = div_q[DW];

   always_comb begin
      fprev = tbl_q[upd.flow];
      start = upd.vtime;
      if (!upd.idle && (fprev > upd.vtime)) start = fprev;
      sum       = {1'b0, start} + {1'b0, upd.quo};
      res_d     = '0;
      res_d.vld = upd.vld;
      res_d.flow  = upd.flow;
      res_d.ftime = sum[DW-1:0];
      res_d.ovf   = sum[DW] | upd.wz;
      if (sum[DW] && (SAT != 0)) res_d.ftime = '1;
   end

   always_ff @(posedge clk) begin
      if (tbl_clr) begin
         tbl_q[sweep_q] <= '0;
      end else if (!rst && upd.vld) begin
         tbl_q[upd.flow] <= res_d.ftime;
      end
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DW; i++) div_q[i] <= '0;
         for (int i = 0; i < 4; i++) res_q[i] <= '0;
      end else begin
         for (int i = 0; i <= DW; i++) div_q[i] <= div_d[i];
         res_q[0] <= res_d;
         for (int i = 1; i < 4; i++) res_q[i] <= res_q[i-1];
      end
   end

   assign bus.out_valid = res_q[3].vld;
   assign bus.out_flow  = res_q[3].flow;
   assign bus.out_ftime = res_q[3].ftime;
   assign bus.out_ovf   = res_q[3].ovf;

endmodule

// File: tb/tb_wfq_ftime_pipe.sv
// Scoreboard bench: two engines (SAT=1 and SAT=0) driven with the same directed requests.
module tb_wfq_ftime_pipe;
   localparam int DW  = 16;
   localparam int FW  = 4;
   localparam int LAT = DW + 4;

   typedef struct {
      logic [FW-1:0] flow;
      logic [DW-1:0] ft;
      logic          ovf;
      int            acc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   wfq_ftime_pipe_if #(.DW(DW), .FW(FW)) bus0 ();
   wfq_ftime_pipe_if #(.DW(DW), .FW(FW)) bus1 ();

   wfq_ftime_pipe #(.DW(DW), .FW(FW), .SAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   wfq_ftime_pipe #(.DW(DW), .FW(FW), .SAT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic vld, input logic [FW-1:0] fl,
                      input logic [DW-1:0] ft, input logic ovf);
      exp_t e;
      int   sz;
      if (vld !== 1'b1) return;
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL d%0d unexpected out_valid: got flow %0d ftime %0d, expected none", d, fl, ft);
         return;
      end
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("d%0d out_flow", d),  fl,  e.flow);
      check($sformatf("d%0d out_ftime", d), ft,  e.ft);
      check($sformatf("d%0d out_ovf", d),   ovf, e.ovf);
      check($sformatf("d%0d latency", d),   cyc - e.acc, LAT);
   endtask

   always @(negedge clk) begin
      mon(0, bus0.out_valid, bus0.out_flow, bus0.out_ftime, bus0.out_ovf);
      mon(1, bus1.out_valid, bus1.out_flow, bus1.out_ftime, bus1.out_ovf);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic vld, input logic [FW-1:0] fl, input logic [DW-1:0] len,
                          input logic [DW-1:0] w, input logic [DW-1:0] v, input logic idle);
      bus0.in_valid = vld; bus0.in_flow = fl; bus0.in_len = len;
      bus0.in_weight = w;  bus0.in_vtime = v; bus0.in_idle = idle;
      bus1.in_valid = vld; bus1.in_flow = fl; bus1.in_len = len;
      bus1.in_weight = w;  bus1.in_vtime = v; bus1.in_idle = idle;
   endtask

   // ft1/ovf1: SAT=1 result, ft0/ovf0: SAT=0 result
   task automatic issue(input logic [FW-1:0] fl, input logic [DW-1:0] len, input logic [DW-1:0] w,
                        input logic [DW-1:0] v, input logic idle,
                        input logic [DW-1:0] ft1, input logic ovf1,
                        input logic [DW-1:0] ft0, input logic ovf0, input bit track);
      exp_t e;
      check("in_ready at issue", {bus0.in_ready, bus1.in_ready}, 2'b11);
      set_req(1'b1, fl, len, w, v, idle);
      tick();
      if (track) begin
         e.flow = fl; e.acc = cyc;
         e.ft = ft1; e.ovf = ovf1; q0.push_back(e);
         e.ft = ft0; e.ovf = ovf0; q1.push_back(e);
      end
      set_req(1'b0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      int c0, c1, g;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q0.delete();
      q1.delete();
      c0 = 0; c1 = 0; g = 0;
      while ((bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) && g < 100) begin
         if (bus0.in_ready !== 1'b1) c0++;
         if (bus1.in_ready !== 1'b1) c1++;
         g++;
         tick();
      end
      check("d0 init ready-low cycles", c0, 16);
      check("d1 init ready-low cycles", c1, 16);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((q0.size() != 0 || q1.size() != 0) && g < 200) begin
         g++;
         tick();
      end
      check("scoreboard drained", q0.size() + q1.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_req(1'b0, '0, '0, '0, '0, 1'b0);
      tick();
      check("reset in_ready",  bus0.in_ready,  0);
      check("reset out_valid", bus0.out_valid, 0);
      check("reset out_flow",  bus0.out_flow,  0);
      check("reset out_ftime", bus0.out_ftime, 0);
      check("reset out_ovf",   bus0.out_ovf,   0);
      check("reset d1 in_ready",  bus1.in_ready,  0);
      check("reset d1 out_valid", bus1.out_valid, 0);
      do_reset();

      // table cleared: F_prev = 0
      issue(7, 8, 2, 0, 0,  4, 0,  4, 0, 1);
      // single packet, idle
      issue(3, 100, 4, 10, 1,  35, 0,  35, 0, 1);
      drain();

      // same flow back-to-back, then 1- and 3-cycle gaps
      issue(3, 100, 4, 10, 1,  35, 0,  35, 0, 1);
      issue(3, 40,  4, 10, 0,  45, 0,  45, 0, 1);
      issue(3, 100, 4, 10, 1,  35, 0,  35, 0, 1);
      tick();
      issue(3, 40,  4, 10, 0,  45, 0,  45, 0, 1);
      issue(3, 100, 4, 10, 1,  35, 0,  35, 0, 1);
      repeat (3) tick();
      issue(3, 40,  4, 10, 0,  45, 0,  45, 0, 1);

      // interleaved flows
      issue(1, 20, 5, 0, 0,  4, 0,  4, 0, 1);
      issue(2, 9,  3, 0, 0,  3, 0,  3, 0, 1);
      issue(1, 5,  5, 2, 0,  5, 0,  5, 0, 1);
      // V above F_prev, idle overriding larger F_prev, equal V and F_prev
      issue(1, 0,  1, 100, 0,  100, 0,  100, 0, 1);
      issue(1, 10, 10, 50, 1,  51, 0,   51, 0, 1);
      issue(1, 3,  1, 51, 0,   54, 0,   54, 0, 1);

      // overflow, zero weight, edges of the divider
      issue(5,  20, 1, 65530, 1,  65535, 1,  14, 1, 1);
      issue(6,  5,  0, 0, 1,      65535, 1,  65535, 1, 1);
      issue(10, 0,  1, 65535, 1,  65535, 0,  65535, 0, 1);
      issue(11, 65535, 65535, 0, 1,  1, 0,  1, 0, 1);
      issue(12, 7, 3, 0, 1,       2, 0,  2, 0, 1);
      issue(13, 65535, 1, 0, 1,   65535, 0,  65535, 0, 1);
      drain();

      // reset with requests in flight: none may emerge, table re-cleared
      for (int i = 0; i < 5; i++) issue(3, 100, 4, 10, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      do_reset();
      issue(3, 8, 2, 0, 0,  4, 0,  4, 0, 1);
      drain();
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
